// File: rtl/panda_wb_pkg.sv
// Shared types and constants for the panda register-file writeback path.
// The top level (panda_regfile_wb_arbiter) honours the PANDA_WB_BYPASS_EN macro.
package panda_wb_pkg;

  localparam int RegWidth = 32;
  localparam int RegAddrW = 5;

  localparam logic PrioA = 1'b0;
  localparam logic PrioB = 1'b1;

  typedef struct packed {
    logic [RegAddrW-1:0] addr;
    logic [RegWidth-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/panda_rr_arbiter2.sv
// Two-requester round-robin arbiter: req[0] is port A, req[1] is port B.
// A grant passes priority to the other requester; no grant holds it.
module panda_rr_arbiter2
  import panda_wb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    gnt = 2'b00;
    if (req[0] && (!req[1] || prio == PrioA)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      prio <= PrioA;
    end else if (gnt[0]) begin
      prio <= PrioB;
    end else if (gnt[1]) begin
      prio <= PrioA;
    end
  end

endmodule

// File: rtl/panda_regfile_wb_arbiter.sv
// Shares the register-file write port between writeback ports A and B.
// Define PANDA_WB_BYPASS_EN to forward the in-flight write to rs1/rs2.
module panda_regfile_wb_arbiter #(
  parameter int Width    = 32,
  parameter int Depth    = 32,
  parameter int CntWidth = 16,
  localparam int AddrW   = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [AddrW-1:0]    a_addr_i,
  input  logic [Width-1:0]    a_data_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [AddrW-1:0]    b_addr_i,
  input  logic [Width-1:0]    b_data_i,
  output logic [AddrW-1:0]    rd_addr_o,
  output logic [Width-1:0]    rd_data_o,
  output logic                rd_we_o,
  input  logic [AddrW-1:0]    rs1_addr_i,
  input  logic [Width-1:0]    rs1_data_i,
  output logic [Width-1:0]    rs1_data_o,
  input  logic [AddrW-1:0]    rs2_addr_i,
  input  logic [Width-1:0]    rs2_data_i,
  output logic [Width-1:0]    rs2_data_o,
  output logic [CntWidth-1:0] conflict_cnt_o
);

  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [1:0] gnt;

  panda_rr_arbiter2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   ({b_valid_i, a_valid_i}),
    .gnt   (gnt)
  );

  assign a_ready_o = gnt[0];
  assign b_ready_o = gnt[1];

  // Writes to x0 are accepted but never raise the write enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_we_o   <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else if (gnt[0]) begin
      rd_we_o   <= (a_addr_i != '0);
      rd_addr_o <= a_addr_i;
      rd_data_o <= a_data_i;
    end else if (gnt[1]) begin
      rd_we_o   <= (b_addr_i != '0);
      rd_addr_o <= b_addr_i;
      rd_data_o <= b_data_i;
    end else begin
      rd_we_o   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
    end else if (a_valid_i && b_valid_i && conflict_cnt_o != CntMax) begin
      conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
  end

`ifdef PANDA_WB_BYPASS_EN
  assign rs1_data_o = (rd_we_o && rd_addr_o == rs1_addr_i && rs1_addr_i != '0) ? rd_data_o
                                                                              : rs1_data_i;
  assign rs2_data_o = (rd_we_o && rd_addr_o == rs2_addr_i && rs2_addr_i != '0) ? rd_data_o
                                                                              : rs2_data_i;
`else
  // Read addresses only matter for forwarding; keep them tied off here.
  logic unused_rs_addr;
  assign unused_rs_addr = ^{rs1_addr_i, rs2_addr_i};
  assign rs1_data_o     = rs1_data_i;
  assign rs2_data_o     = rs2_data_i;
`endif

endmodule

// File: tb/tb_panda_regfile_wb_arbiter.sv
// Self-checking bench for panda_regfile_wb_arbiter against a transaction-level model.
// Builds with or without PANDA_WB_BYPASS_EN; expectations follow the build.
module tb_panda_regfile_wb_arbiter;
  import panda_wb_pkg::*;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          a_valid_i, b_valid_i;
  logic          a_ready_o, b_ready_o;
  logic [AW-1:0] a_addr_i, b_addr_i, rd_addr_o, rs1_addr_i, rs2_addr_i;
  logic [W-1:0]  a_data_i, b_data_i, rd_data_o, rs1_data_i, rs2_data_i, rs1_data_o, rs2_data_o;
  logic          rd_we_o;
  logic [CW-1:0] conflict_cnt_o;

  always #5 clk = ~clk;

  panda_regfile_wb_arbiter #(.Width(W), .Depth(D), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_we_o(rd_we_o),
    .rs1_addr_i(rs1_addr_i), .rs1_data_i(rs1_data_i), .rs1_data_o(rs1_data_o),
    .rs2_addr_i(rs2_addr_i), .rs2_data_i(rs2_data_i), .rs2_data_o(rs2_data_o),
    .conflict_cnt_o(conflict_cnt_o)
  );

  int errors = 0;
  int checks = 0;

  // Model: the last committed write, who was granted most recently, and a plain integer count.
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;
  int            m_cnt;
  bit            m_last_was_a;

  function automatic logic [W-1:0] exp_rs(logic [AW-1:0] a, logic [W-1:0] d);
`ifdef PANDA_WB_BYPASS_EN
    return (m_we && m_addr == a && a != 0) ? m_data : d;
`else
    return d;
`endif
  endfunction

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick(output bit ga, output bit gb);
    bit      ea, eb, av, bv, r;
    wb_req_t ra, rb;
    #1;
    av = a_valid_i; bv = b_valid_i; r = rst_i;
    ra = '{addr: a_addr_i, data: a_data_i};
    rb = '{addr: b_addr_i, data: b_data_i};
    // The port granted less recently wins a tie.
    ea = av && (!bv || !m_last_was_a);
    eb = bv && !ea;
    if (!r) begin
      checks++;
      if (a_ready_o !== ea || b_ready_o !== eb) begin
        errors++;
        $display("FAIL ready: got a=%b b=%b, expected a=%b b=%b", a_ready_o, b_ready_o, ea, eb);
      end
      checks++;
      if (rs1_data_o !== exp_rs(rs1_addr_i, rs1_data_i) ||
          rs2_data_o !== exp_rs(rs2_addr_i, rs2_data_i)) begin
        errors++;
        $display("FAIL rs_data: got rs1=%h rs2=%h, expected rs1=%h rs2=%h", rs1_data_o, rs2_data_o,
                 exp_rs(rs1_addr_i, rs1_data_i), exp_rs(rs2_addr_i, rs2_data_i));
      end
    end
    @(posedge clk);
    ga = 1'b0; gb = 1'b0;
    if (r) begin
      m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0; m_last_was_a = 1'b0;
    end else begin
      if (ea) begin
        ga = 1'b1; m_we = (ra.addr != 0); m_addr = ra.addr; m_data = ra.data; m_last_was_a = 1'b1;
      end else if (eb) begin
        gb = 1'b1; m_we = (rb.addr != 0); m_addr = rb.addr; m_data = rb.data; m_last_was_a = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (av && bv) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end
    #1;
    checks++;
    if (rd_we_o !== m_we || rd_addr_o !== m_addr || rd_data_o !== m_data ||
        conflict_cnt_o !== m_cnt[CW-1:0]) begin
      errors++;
      $display("FAIL write_port: got we=%b addr=%0d data=%h cnt=%0d, expected we=%b addr=%0d data=%h cnt=%0d",
               rd_we_o, rd_addr_o, rd_data_o, conflict_cnt_o, m_we, m_addr, m_data, m_cnt);
    end
  endtask

  task automatic test_reset();
    bit ga, gb;
    rst_i = 1'b1;
    a_valid_i = 1'b1; a_addr_i = 5'd3; a_data_i = 32'hA0A0_0003;
    b_valid_i = 1'b1; b_addr_i = 5'd9; b_data_i = 32'hB0B0_0009;
    rs1_addr_i = '0; rs1_data_i = '0; rs2_addr_i = '0; rs2_data_i = '0;
    tick(ga, gb);
    tick(ga, gb);
    rst_i = 1'b0;
    checks++;
    if (rd_we_o !== 1'b0 || conflict_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_state: got we=%b cnt=%0d, expected we=0 cnt=0", rd_we_o, conflict_cnt_o);
    end
    #1;
    checks++;
    if (a_ready_o !== 1'b1 || b_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_tie: got a=%b b=%b, expected a=1 b=0", a_ready_o, b_ready_o);
    end
    tick(ga, gb);
    a_valid_i = 1'b0;
    tick(ga, gb);
    checks++;
    if (gb !== 1'b1 || rd_addr_o !== 5'd9) begin
      errors++;
      $display("FAIL reset_loser_next: got gb=%b addr=%0d, expected gb=1 addr=9", gb, rd_addr_o);
    end
    b_valid_i = 1'b0;
    tick(ga, gb);
  endtask

  task automatic test_single();
    bit ga, gb;
    a_valid_i = 1'b1; a_addr_i = 5'd5; a_data_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (a_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b, expected 1", a_ready_o);
    end
    tick(ga, gb);
    a_valid_i = 1'b0;
    checks++;
    if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd5 || rd_data_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_write: got we=%b addr=%0d data=%h, expected we=1 addr=5 data=deadbeef",
               rd_we_o, rd_addr_o, rd_data_o);
    end
    tick(ga, gb);
    checks++;
    if (rd_we_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got we=%b, expected 0", rd_we_o);
    end
  endtask

  task automatic test_x0();
    bit ga, gb;
    b_valid_i = 1'b1; b_addr_i = 5'd0; b_data_i = 32'h0000_1234;
    tick(ga, gb);
    b_valid_i = 1'b0;
    checks++;
    if (gb !== 1'b1 || rd_we_o !== 1'b0) begin
      errors++;
      $display("FAIL x0_drop: got gnt_b=%b we=%b, expected gnt_b=1 we=0", gb, rd_we_o);
    end
    tick(ga, gb);
  endtask

  task automatic test_tie();
    bit            ga, gb;
    int            cnt0;
    logic [AW-1:0] exp_addr [4];
    exp_addr = '{5'd1, 5'd11, 5'd2, 5'd12};
    cnt0 = m_cnt;
    a_valid_i = 1'b1; a_addr_i = 5'd1;  a_data_i = 32'h1;
    b_valid_i = 1'b1; b_addr_i = 5'd11; b_data_i = 32'h11;
    for (int i = 0; i < 4; i++) begin
      tick(ga, gb);
      checks++;
      if (rd_addr_o !== exp_addr[i] || rd_we_o !== 1'b1) begin
        errors++;
        $display("FAIL tie_order[%0d]: got addr=%0d we=%b, expected addr=%0d we=1",
                 i, rd_addr_o, rd_we_o, exp_addr[i]);
      end
      if (ga) begin a_addr_i = a_addr_i + 1'b1; a_data_i = a_data_i + 1; end
      if (gb) begin b_addr_i = b_addr_i + 1'b1; b_data_i = b_data_i + 1; end
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    checks++;
    if (conflict_cnt_o !== CW'((cnt0 + 4 > CNT_MAX) ? CNT_MAX : cnt0 + 4)) begin
      errors++;
      $display("FAIL tie_count: got %0d, expected %0d", conflict_cnt_o, cnt0 + 4);
    end
    tick(ga, gb);
  endtask

  task automatic test_bypass();
    bit ga, gb;
    a_valid_i = 1'b1; a_addr_i = 5'd7; a_data_i = 32'hCAFE_0001;
    tick(ga, gb);
    a_valid_i = 1'b0;
    rs1_addr_i = 5'd7; rs1_data_i = 32'h0;
    rs2_addr_i = 5'd0; rs2_data_i = 32'h55AA_55AA;
    #1;
    checks++;
`ifdef PANDA_WB_BYPASS_EN
    if (rs1_data_o !== 32'hCAFE_0001 || rs2_data_o !== 32'h55AA_55AA) begin
`else
    if (rs1_data_o !== 32'h0 || rs2_data_o !== 32'h55AA_55AA) begin
`endif
      errors++;
      $display("FAIL bypass: got rs1=%h rs2=%h", rs1_data_o, rs2_data_o);
    end
    tick(ga, gb);
  endtask

  task automatic test_random();
    bit ga, gb;
    ga = 1'b0; gb = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!a_valid_i || ga) begin
        a_valid_i = ($urandom_range(0, 2) != 0);
        a_addr_i  = AW'($urandom_range(0, D - 1));
        a_data_i  = $urandom;
      end
      if (!b_valid_i || gb) begin
        b_valid_i = ($urandom_range(0, 2) != 0);
        b_addr_i  = ($urandom_range(0, 3) == 0) ? a_addr_i : AW'($urandom_range(0, D - 1));
        b_data_i  = $urandom;
      end
      rs1_addr_i = ($urandom_range(0, 1) != 0) ? m_addr : AW'($urandom_range(0, D - 1));
      rs2_addr_i = ($urandom_range(0, 1) != 0) ? m_addr : AW'($urandom_range(0, D - 1));
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
      tick(ga, gb);
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    tick(ga, gb);
  endtask

  task automatic test_reset_overrides_accept();
    bit ga, gb;
    a_valid_i = 1'b1; a_addr_i = 5'd21; a_data_i = 32'h2121_2121;
    rst_i = 1'b1;
    tick(ga, gb);
    rst_i = 1'b0; a_valid_i = 1'b0;
    checks++;
    if (rd_we_o !== 1'b0 || rd_addr_o !== '0 || rd_data_o !== '0 || conflict_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_accept: got we=%b addr=%0d data=%h cnt=%0d, expected all zero",
               rd_we_o, rd_addr_o, rd_data_o, conflict_cnt_o);
    end
    tick(ga, gb);
  endtask

  task automatic test_saturation();
    bit ga, gb;
    a_valid_i = 1'b1; a_addr_i = 5'd2;  a_data_i = $urandom;
    b_valid_i = 1'b1; b_addr_i = 5'd30; b_data_i = $urandom;
    for (int i = 0; i < 20; i++) begin
      tick(ga, gb);
      if (ga) a_data_i = $urandom;
      if (gb) b_data_i = $urandom;
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    checks++;
    if (conflict_cnt_o !== CW'(CNT_MAX)) begin
      errors++;
      $display("FAIL saturation: got %0d, expected %0d", conflict_cnt_o, CNT_MAX);
    end
    tick(ga, gb);
    checks++;
    if (conflict_cnt_o !== CW'(CNT_MAX)) begin
      errors++;
      $display("FAIL saturation_hold: got %0d, expected %0d", conflict_cnt_o, CNT_MAX);
    end
  endtask

  initial begin
    m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0; m_last_was_a = 1'b0;
    test_reset();
    test_single();
    test_x0();
    test_tie();
    test_bypass();
    test_random();
    test_reset_overrides_accept();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/panda_regfile_wb_arbiter.md
Name: panda_regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: port A (ALU/CSR result) and port B (load unit result).
- Each requester uses a valid/ready handshake. Arbitration is 2-way round-robin; one write is committed per cycle through a registered output stage.
- Keeps a saturating count of contention cycles for performance monitoring.
- Optionally forwards the in-flight write to the two read ports.
- Sits between the execute/memory stages and panda_register_file.

Parameters:
- Width, 32, data width of one register.
- Depth, 32, number of architectural registers; AddrW = $clog2(Depth).
- CntWidth, 16, width of the contention counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- a_valid_i  in  1  port A write request.
- a_ready_o  out  1  port A request accepted this cycle.
- a_addr_i  in  AddrW  port A destination register.
- a_data_i  in  Width  port A write data.
- b_valid_i  in  1  port B write request.
- b_ready_o  out  1  port B request accepted this cycle.
- b_addr_i  in  AddrW  port B destination register.
- b_data_i  in  Width  port B write data.
- rd_addr_o  out  AddrW  register file write address.
- rd_data_o  out  Width  register file write data.
- rd_we_o  out  1  register file write enable.
- rs1_addr_i  in  AddrW  read port 1 address (bypass compare).
- rs1_data_i  in  Width  read port 1 data from register file.
- rs1_data_o  out  Width  read port 1 data to consumer.
- rs2_addr_i  in  AddrW  read port 2 address.
- rs2_data_i  in  Width  read port 2 data from register file.
- rs2_data_o  out  Width  read port 2 data to consumer.
- conflict_cnt_o  out  CntWidth  count of cycles with both valids high.

Behaviour:
- Reset (rst_i high at a rising edge) sets:
  - rd_we_o=0, rd_addr_o=0, rd_data_o=0;
  - conflict_cnt_o=0;
  - priority flop prio=0, meaning A wins the first tie.
- Reset overrides everything, including an accept in the same cycle. An in-flight write is dropped, and rd_we_o is 0 in the cycle after reset.
- Handshake:
  - Transfer occurs when valid and ready are both high at a rising edge.
  - valid must not depend on ready. Once asserted, valid, addr and data stay stable until accepted.
  - ready is combinational from both valids and prio.
- Grant rules:
  - Only A valid: a_ready_o=1.
  - Only B valid: b_ready_o=1.
  - Both valid: the port selected by prio (0=A, 1=B) gets ready; the other port's ready is 0.
  - Neither valid: both readys are 0.
  - At most one ready is high per cycle.
- prio update: after an A grant, prio becomes 1; after a B grant, prio becomes 0; with no grant, it holds. A still-valid loser therefore wins the next cycle (starvation-free, maximum wait 1 cycle).
- Output stage, 1-cycle latency from accept to write:
  - On accept: rd_addr_o and rd_data_o load the granted addr/data; rd_we_o = (granted addr != 0).
  - With no accept: rd_we_o=0, and rd_addr_o/rd_data_o hold their values.
- x0 writes are accepted (ready asserted, prio updated) but never produce rd_we_o=1.
- Same destination on both ports in one cycle: both are written on consecutive cycles in grant order, so the last write wins in the register file. Ordering between ports is the issue logic's responsibility.
- Throughput: one write per cycle sustained. Back-to-back accepts on the same port are allowed when the other port is idle.
- conflict_cnt_o increments by 1 on every cycle where a_valid_i and b_valid_i are both high. It saturates at 2^CntWidth-1 and does not wrap.

Optional Feature:
- Macro PANDA_WB_BYPASS_EN.
- Defined: rsN_data_o = rd_data_o when rd_we_o=1 and rd_addr_o==rsN_addr_i and rsN_addr_i!=0; otherwise rsN_data_o = rsN_data_i. This is combinational and applies independently to rs1 and rs2.
- Undefined: rsN_data_o = rsN_data_i (pure passthrough). Ports remain present so the instantiation is identical in both builds.

Decomposition:
- Package panda_wb_pkg:
  - typedef wb_req_t struct {addr, data}, parameterised via package localparams RegWidth=32 and RegAddrW=5;
  - localparam PrioA=1'b0, PrioB=1'b1.
- Sub-module panda_rr_arbiter2: 2-requester round-robin grant logic holding the prio flop. Inputs req[1:0]; outputs gnt[1:0]. The top level holds the output register, counter and bypass.

Test Plan:
- Reset: hold rst_i 2 cycles with both valids high -> readys may assert but rd_we_o=0 and conflict_cnt_o=0 through the cycle after rst_i falls; first tie then grants A.
- Single port: A writes addr 5, data 0xDEADBEEF -> a_ready_o=1 same cycle; next cycle rd_we_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF; following cycle rd_we_o=0.
- Tie alternation: both valid for 4 cycles (A addr 1..4, B addr 11..14, each advancing on accept) -> grants A1,B11,A2,B12; conflict_cnt_o=4.
- x0 drop: B writes addr 0, data 0x1234 -> b_ready_o=1, rd_we_o stays 0, prio flips to A.
- Bypass (macro defined): output stage writing addr 7 = 0xCAFE0001, rs1_addr_i=7, rs1_data_i=0 -> rs1_data_o=0xCAFE0001; rs2_addr_i=0 -> rs2_data_o=rs2_data_i. Macro undefined -> rs1_data_o=0.
- Saturation (CntWidth=4): both valid for 20 cycles -> conflict_cnt_o stops at 15.
